// File: rtl/cp0_tlb_op_sched_pkg.sv
// Shared definitions for the CP0 TLB operation scheduler.
// Provides the one-hot TLB op bit indices (also as `TLBOP_* macros), the
// scheduler state enum and the virtual address type.
`ifndef TLBOP_TLBP
`define TLBOP_TLBP 0
`endif
`ifndef TLBOP_TLBR
`define TLBOP_TLBR 1
`endif
`ifndef TLBOP_TLBWI
`define TLBOP_TLBWI 2
`endif
`ifndef TLBOP_TLBWR
`define TLBOP_TLBWR 3
`endif

package cp0_tlb_op_sched_pkg;

  localparam int TLBOP_TLBP  = `TLBOP_TLBP;
  localparam int TLBOP_TLBR  = `TLBOP_TLBR;
  localparam int TLBOP_TLBWI = `TLBOP_TLBWI;
  localparam int TLBOP_TLBWR = `TLBOP_TLBWR;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    LOOKUP,
    EXEC,
    FLUSH
  } tlb_sched_state_e;

  typedef logic [31:0] virt_t;

endpackage

// File: rtl/cp0_tlb_op_sched_if.sv
// Commit-side request handshake plus the TLBP probe handshake.
// Ports: req_valid/req_op/req_pc/req_ready (commit -> scheduler, valid/ready),
//        tlbp_req/tlbp_ack (scheduler -> TLB lookup unit, request/ack).
// master = commit stage and TLB lookup unit; slave = the scheduler.
interface cp0_tlb_op_sched_if #(
  parameter int TLBOP_W = 4,
  parameter int ADDR_W  = 32
) ();

  logic               req_valid;
  logic [TLBOP_W-1:0] req_op;
  logic [ADDR_W-1:0]  req_pc;
  logic               req_ready;
  logic               tlbp_req;
  logic               tlbp_ack;

  modport master (
    output req_valid, req_op, req_pc, tlbp_ack,
    input  req_ready, tlbp_req
  );

  modport slave (
    input  req_valid, req_op, req_pc, tlbp_ack,
    output req_ready, tlbp_req
  );

endinterface

// File: rtl/tlb_seq_perf_cnt.sv
// Saturating event counter for the TLB scheduler performance statistics.
// Ports: clk, resetn (sync, active-low), inc (count this cycle), cnt (value).
// Holds at all-ones once reached.
module tlb_seq_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cp0_tlb_op_sched.sv
// Sequences TLBP/TLBR/TLBWI/TLBWR from commit into CP0/TLB: stalls, drains
// in-flight translations, pulses tlb_op, then flushes after TLB writes.
// Ports: clk, resetn (sync, active-low), bus (request + probe handshake),
//        abort, mem_busy in; tlb_op, stall, flush_valid, flush_pc, done,
//        op_err, perf_ops, perf_stall out.
// Optional feature macro: TLB_SEQ_PERF_EN enables saturating perf counters.
module cp0_tlb_op_sched
  import cp0_tlb_op_sched_pkg::*;
#(
  parameter int TLBOP_W = 4,
  parameter int ADDR_W  = 32,
  parameter int PERF_W  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  cp0_tlb_op_sched_if.slave  bus,
  input  logic               abort,
  input  logic               mem_busy,
  output logic [TLBOP_W-1:0] tlb_op,
  output logic               stall,
  output logic               flush_valid,
  output logic [ADDR_W-1:0]  flush_pc,
  output logic               done,
  output logic               op_err,
  output logic [PERF_W-1:0]  perf_ops,
  output logic [PERF_W-1:0]  perf_stall
);

  localparam logic [TLBOP_W-1:0] OP_TLBP = TLBOP_W'(1) << TLBOP_TLBP;

  tlb_sched_state_e   state, state_nx;
  logic [TLBOP_W-1:0] op_q;
  logic [ADDR_W-1:0]  pc_q;
  logic               accept;
  logic               probe_hit;

  // abort from an older instruction blocks acceptance of the same-cycle request
  assign accept    = (state == IDLE) && bus.req_valid && $onehot(bus.req_op) && !abort;
  // abort wins over a coincident probe ack
  assign probe_hit = (state == LOOKUP) && bus.tlbp_ack && !abort;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q <= '0;
      pc_q <= '0;
    end else if (accept) begin
      op_q <= bus.req_op;
      pc_q <= bus.req_pc;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = DRAIN;
      DRAIN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (!mem_busy) begin
          state_nx = op_q[TLBOP_TLBP] ? LOOKUP : EXEC;
        end
      end
      LOOKUP:  if (abort || bus.tlbp_ack) state_nx = IDLE;
      // past this point the op is architecturally committed; abort is ignored
      EXEC:    state_nx = op_q[TLBOP_TLBR] ? IDLE : FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.tlbp_req  = (state == LOOKUP);
    stall         = (state != IDLE);
    tlb_op        = '0;
    done          = 1'b0;
    flush_valid   = 1'b0;
    flush_pc      = '0;
    op_err        = 1'b0;
    case (state)
      IDLE:   op_err = bus.req_valid && !abort && !$onehot(bus.req_op);
      LOOKUP: begin
        if (probe_hit) begin
          tlb_op = OP_TLBP;
          done   = 1'b1;
        end
      end
      EXEC: begin
        tlb_op = op_q;
        done   = op_q[TLBOP_TLBR];
      end
      FLUSH: begin
        flush_valid = 1'b1;
        flush_pc    = pc_q + ADDR_W'(4);
        done        = 1'b1;
      end
      default: ;
    endcase
    // a reset landing mid-operation must not leak a commit pulse
    if (!resetn) begin
      tlb_op      = '0;
      done        = 1'b0;
      flush_valid = 1'b0;
      flush_pc    = '0;
      op_err      = 1'b0;
    end
  end

`ifdef TLB_SEQ_PERF_EN
  tlb_seq_perf_cnt #(.W(PERF_W)) u_perf_ops (
    .clk    (clk),
    .resetn (resetn),
    .inc    (done),
    .cnt    (perf_ops)
  );

  tlb_seq_perf_cnt #(.W(PERF_W)) u_perf_stall (
    .clk    (clk),
    .resetn (resetn),
    .inc    (stall),
    .cnt    (perf_stall)
  );
`else
  assign perf_ops   = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_cp0_tlb_op_sched.sv
// Self-checking bench for cp0_tlb_op_sched: directed scenarios with literal
// expectations, plus a per-cycle transaction model compared on every cycle.
// Ports: none (top-level bench).
module tb_cp0_tlb_op_sched;

  localparam logic [3:0] OP_P  = 4'b0001;
  localparam logic [3:0] OP_R  = 4'b0010;
  localparam logic [3:0] OP_WI = 4'b0100;
  localparam logic [3:0] OP_WR = 4'b1000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        abort = 1'b0;
  logic        mem_busy = 1'b0;
  logic [3:0]  tlb_op;
  logic        stall;
  logic        flush_valid;
  logic [31:0] flush_pc;
  logic        done;
  logic        op_err;
  logic [31:0] perf_ops;
  logic [31:0] perf_stall;

  int n_cmp = 0;
  int n_err = 0;
  bit run = 1'b0;

  cp0_tlb_op_sched_if #(.TLBOP_W(4), .ADDR_W(32)) bus ();

  cp0_tlb_op_sched #(.TLBOP_W(4), .ADDR_W(32), .PERF_W(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .abort       (abort),
    .mem_busy    (mem_busy),
    .tlb_op      (tlb_op),
    .stall       (stall),
    .flush_valid (flush_valid),
    .flush_pc    (flush_pc),
    .done        (done),
    .op_err      (op_err),
    .perf_ops    (perf_ops),
    .perf_stall  (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: dut=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- transaction model ----------------
  // An accepted op is "pending" until it issues; a pending op first waits out
  // the drain, then (TLBP only) waits for the probe ack. A non-probe op issues
  // the cycle after the drain ends; TLB writes owe one flush cycle afterwards.
  bit          m_pend, m_probe, m_issue_due, m_flush_due;
  logic [3:0]  m_op;
  logic [31:0] m_pc;
  int unsigned m_ops, m_stall;

  logic        e_idle, e_tlbp_req, e_done, e_fv, e_err;
  logic [3:0]  e_op;
  logic [31:0] e_fpc;

  always @(negedge clk) begin
    if (run) begin
      e_idle     = !(m_pend || m_issue_due || m_flush_due);
      e_tlbp_req = m_pend && m_probe;
      e_op = 4'b0; e_done = 1'b0; e_fv = 1'b0; e_fpc = 32'h0; e_err = 1'b0;
      if (m_issue_due) begin
        e_op   = m_op;
        e_done = (m_op == OP_R);
      end
      if (m_flush_due) begin
        e_fv   = 1'b1;
        e_fpc  = m_pc + 32'd4;
        e_done = 1'b1;
      end
      if (e_tlbp_req && bus.tlbp_ack && !abort) begin
        e_op   = OP_P;
        e_done = 1'b1;
      end
      if (e_idle && bus.req_valid && !abort && ($countones(bus.req_op) != 1)) e_err = 1'b1;
      if (!resetn) begin
        e_op = 4'b0; e_done = 1'b0; e_fv = 1'b0; e_fpc = 32'h0; e_err = 1'b0;
      end

      cmp("req_ready",   {31'b0, bus.req_ready}, {31'b0, e_idle});
      cmp("stall",       {31'b0, stall},         {31'b0, !e_idle});
      cmp("tlbp_req",    {31'b0, bus.tlbp_req},  {31'b0, e_tlbp_req});
      cmp("tlb_op",      {28'b0, tlb_op},        {28'b0, e_op});
      cmp("flush_valid", {31'b0, flush_valid},   {31'b0, e_fv});
      cmp("flush_pc",    flush_pc,               e_fpc);
      cmp("done",        {31'b0, done},          {31'b0, e_done});
      cmp("op_err",      {31'b0, op_err},        {31'b0, e_err});
      cmp("op_excl",     {31'b0, (tlb_op != 4'b0) && flush_valid}, 32'h0);
`ifdef TLB_SEQ_PERF_EN
      cmp("perf_ops",    perf_ops,   m_ops);
      cmp("perf_stall",  perf_stall, m_stall);
`else
      cmp("perf_ops",    perf_ops,   32'h0);
      cmp("perf_stall",  perf_stall, 32'h0);
`endif

      if (!resetn) begin
        m_pend = 0; m_probe = 0; m_issue_due = 0; m_flush_due = 0;
        m_op = 4'b0; m_pc = 32'h0; m_ops = 0; m_stall = 0;
      end else begin
        if (e_done) m_ops++;
        if (!e_idle) m_stall++;
        m_flush_due = 1'b0;
        if (m_issue_due) begin
          m_issue_due = 1'b0;
          m_flush_due = (m_op == OP_WI) || (m_op == OP_WR);
        end
        if (m_pend) begin
          if (abort) begin
            m_pend = 0; m_probe = 0;
          end else if (m_probe) begin
            if (bus.tlbp_ack) begin m_pend = 0; m_probe = 0; end
          end else if (!mem_busy) begin
            if (m_op == OP_P) m_probe = 1'b1;
            else begin m_pend = 1'b0; m_issue_due = 1'b1; end
          end
        end else if (e_idle && bus.req_valid && !abort && ($countones(bus.req_op) == 1)) begin
          m_pend = 1'b1;
          m_op   = bus.req_op;
          m_pc   = bus.req_pc;
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [3:0] op, input logic [31:0] pc);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_pc    = pc;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 4'b0;
    bus.req_pc    = 32'h0;
    bus.tlbp_ack  = 1'b0;

    // reset
    tick();
    run = 1'b1;
    tick();
    resetn = 1'b1;
    #2;
    cmp("rst_ready", {31'b0, bus.req_ready}, 32'h1);
    cmp("rst_stall", {31'b0, stall}, 32'h0);
    cmp("rst_tlbop", {28'b0, tlb_op}, 32'h0);

    // TLBWI, no drain wait: c2 tlb_op, c3 flush+done
    tick(); req(OP_WI, 32'h8000_1000);
    tick(); bus.req_valid = 1'b0; #2 cmp("wi_c1_stall", {31'b0, stall}, 32'h1);
    tick(); #2 cmp("wi_c2_op", {28'b0, tlb_op}, 32'h4);
    tick(); #2;
    cmp("wi_c3_fv",   {31'b0, flush_valid}, 32'h1);
    cmp("wi_c3_fpc",  flush_pc, 32'h8000_1004);
    cmp("wi_c3_done", {31'b0, done}, 32'h1);

    // TLBP, mem_busy held 3 cycles, ack 2 cycles after the probe starts
    tick(); req(OP_P, 32'h8000_2000); mem_busy = 1'b1;
    tick(); bus.req_valid = 1'b0;
    tick();
    tick(); mem_busy = 1'b0; #2 cmp("p_c3_noprobe", {31'b0, bus.tlbp_req}, 32'h0);
    tick(); #2 cmp("p_c4_probe", {31'b0, bus.tlbp_req}, 32'h1);
    tick(); #2 cmp("p_c5_noop", {28'b0, tlb_op}, 32'h0);
    tick(); bus.tlbp_ack = 1'b1; #2;
    cmp("p_c6_op",   {28'b0, tlb_op}, 32'h1);
    cmp("p_c6_done", {31'b0, done}, 32'h1);
    tick(); bus.tlbp_ack = 1'b0; #2 cmp("p_c7_ready", {31'b0, bus.req_ready}, 32'h1);

    // TLBR: pulse and done together, no flush
    req(OP_R, 32'h0000_0200);
    tick(); bus.req_valid = 1'b0;
    tick(); #2;
    cmp("r_c2_op",   {28'b0, tlb_op}, 32'h2);
    cmp("r_c2_done", {31'b0, done}, 32'h1);
    cmp("r_c2_fv",   {31'b0, flush_valid}, 32'h0);
    tick(); #2;
`ifdef TLB_SEQ_PERF_EN
    cmp("perf_ops_3",     perf_ops, 32'd3);
    cmp("perf_stall_11",  perf_stall, 32'd11);
`endif

    // abort coincident with probe ack: no pulse
    req(OP_P, 32'h0000_0300);
    tick(); bus.req_valid = 1'b0;
    tick(); bus.tlbp_ack = 1'b1; abort = 1'b1; #2;
    cmp("ab_lk_op",   {28'b0, tlb_op}, 32'h0);
    cmp("ab_lk_done", {31'b0, done}, 32'h0);
    tick(); bus.tlbp_ack = 1'b0; abort = 1'b0; #2 cmp("ab_lk_idle", {31'b0, bus.req_ready}, 32'h1);

    // malformed ops
    req(4'b0110, 32'h0000_0400); #2;
    cmp("err_multi", {31'b0, op_err}, 32'h1);
    cmp("err_stall", {31'b0, stall}, 32'h0);
    tick(); bus.req_op = 4'b0000; #2 cmp("err_zero", {31'b0, op_err}, 32'h1);
    tick(); bus.req_valid = 1'b0; #2 cmp("err_still_idle", {31'b0, stall}, 32'h0);

    // abort in DRAIN cancels; abort in IDLE blocks acceptance
    tick(); req(OP_WR, 32'h0000_1000);
    tick(); bus.req_valid = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0; #2 cmp("ab_dr_idle", {31'b0, bus.req_ready}, 32'h1);
    req(OP_R, 32'h0000_1100); abort = 1'b1;
    tick(); bus.req_valid = 1'b0; abort = 1'b0; #2 cmp("ab_idle_noacc", {31'b0, stall}, 32'h0);

    // abort in EXEC is ignored
    tick(); req(OP_WI, 32'h0000_2000);
    tick(); bus.req_valid = 1'b0;
    tick(); abort = 1'b1; #2 cmp("ab_ex_op", {28'b0, tlb_op}, 32'h4);
    tick(); abort = 1'b0; #2 cmp("ab_ex_fpc", flush_pc, 32'h0000_2004);

    // reset during DRAIN, then pc wrap on flush
    tick(); req(OP_WR, 32'hFFFF_FFFC);
    tick(); bus.req_valid = 1'b0; resetn = 1'b0;
    tick(); resetn = 1'b1; #2;
    cmp("rd_ready", {31'b0, bus.req_ready}, 32'h1);
    cmp("rd_stall", {31'b0, stall}, 32'h0);
`ifdef TLB_SEQ_PERF_EN
    cmp("rd_perf_ops", perf_ops, 32'd0);
`endif
    req(OP_WR, 32'hFFFF_FFFC);
    tick(); bus.req_valid = 1'b0;
    tick(); #2 cmp("wr_op", {28'b0, tlb_op}, 32'h8);
    tick(); #2;
    cmp("wr_fv",  {31'b0, flush_valid}, 32'h1);
    cmp("wr_fpc", flush_pc, 32'h0000_0000);
    tick();
    tick();

    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
